// File: rtl/lif_neuron_array.sv
// Array of N_NEURONS leaky integrate-and-fire neurons updated in parallel on each timestep strobe.
// Optional per-neuron saturating spike counters are built when LIF_SPIKE_COUNT_EN is defined.
module lif_neuron_array #(
  parameter int N_NEURONS = 4,
  parameter int V_W       = 6,
  parameter int W_W       = 3,
  parameter int LEAK      = 1,
  parameter int REFR_CYC  = 2,
  parameter int REC_W     = 2,
  parameter int THRES_RST = 32,
  parameter int SEL_W     = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_svalid,
  input  logic [N_NEURONS*W_W-1:0] i_wspike,
  input  logic                     i_recc,
  input  logic [V_W-1:0]           i_Thres,
  input  logic                     i_Thres_valid,
  input  logic [SEL_W-1:0]         i_Thres_sel,
  input  logic                     i_Thres_bcast,
`ifdef LIF_SPIKE_COUNT_EN
  input  logic                     i_cnt_clr,
  output logic [N_NEURONS*8-1:0]   o_spike_cnt,
`endif
  output logic [N_NEURONS*V_W-1:0] o_V,
  output logic [N_NEURONS-1:0]     o_spike
);

  localparam int S_W = V_W + 2;
  localparam int R_W = (REFR_CYC < 2) ? 1 : $clog2(REFR_CYC + 1);

  logic [V_W-1:0]       r_v    [N_NEURONS];
  logic [V_W-1:0]       r_thr  [N_NEURONS];
  logic [R_W-1:0]       r_refr [N_NEURONS];
  logic [N_NEURONS-1:0] r_spike;
  logic [N_NEURONS-1:0] r_prev;

  logic [S_W-1:0]       w_sum  [N_NEURONS];
  logic [V_W-1:0]       w_sat  [N_NEURONS];
  logic [N_NEURONS-1:0] w_fire;

  // Sum is formed modulo 2^S_W; the top bit acts as the sign since the true range fits.
  always_comb begin
    w_fire = '0;
    for (int k = 0; k < N_NEURONS; k++) begin
      w_sum[k] = S_W'(r_v[k]) + S_W'(i_wspike[k*W_W +: W_W])
               + ((i_recc && r_prev[(k + N_NEURONS - 1) % N_NEURONS]) ? S_W'(REC_W) : '0)
               - S_W'(LEAK);
      if (w_sum[k][S_W-1])
        w_sat[k] = '0;
      else if (|w_sum[k][S_W-2:V_W])
        w_sat[k] = '1;
      else
        w_sat[k] = w_sum[k][V_W-1:0];
      w_fire[k] = (r_refr[k] == '0) && (r_thr[k] != '0) && (w_sat[k] >= r_thr[k]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_spike <= '0;
      r_prev  <= '0;
      for (int k = 0; k < N_NEURONS; k++) begin
        r_v[k]    <= '0;
        r_refr[k] <= '0;
        r_thr[k]  <= V_W'(THRES_RST);
      end
    end else begin
      if (i_svalid) begin
        r_spike <= w_fire;
        r_prev  <= w_fire;
        for (int k = 0; k < N_NEURONS; k++) begin
          if (r_refr[k] != '0) begin
            r_v[k]    <= '0;
            r_refr[k] <= r_refr[k] - R_W'(1);
          end else if (w_fire[k]) begin
            r_v[k]    <= '0;
            r_refr[k] <= R_W'(REFR_CYC);
          end else begin
            r_v[k]    <= w_sat[k];
          end
        end
      end else begin
        r_spike <= '0;
      end
      // Compare above uses the pre-write threshold, so a same-cycle write lands next timestep.
      if (i_Thres_valid) begin
        for (int k = 0; k < N_NEURONS; k++) begin
          if (i_Thres_bcast || (i_Thres_sel == SEL_W'(k)))
            r_thr[k] <= i_Thres;
        end
      end
    end
  end

  assign o_spike = r_spike;

  genvar g;
  generate
    for (g = 0; g < N_NEURONS; g++) begin : g_vout
      assign o_V[g*V_W +: V_W] = r_v[g];
    end
  endgenerate

`ifdef LIF_SPIKE_COUNT_EN
  logic [7:0] r_cnt [N_NEURONS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N_NEURONS; k++) r_cnt[k] <= '0;
    end else if (i_cnt_clr) begin
      for (int k = 0; k < N_NEURONS; k++) r_cnt[k] <= '0;
    end else if (i_svalid) begin
      for (int k = 0; k < N_NEURONS; k++) begin
        if (w_fire[k] && (r_cnt[k] != 8'hFF))
          r_cnt[k] <= r_cnt[k] + 8'd1;
      end
    end
  end

  generate
    for (g = 0; g < N_NEURONS; g++) begin : g_cout
      assign o_spike_cnt[g*8 +: 8] = r_cnt[g];
    end
  endgenerate
`endif

endmodule

// File: doc/lif_neuron_array.md
Name: lif_neuron_array

Overview:
- Parametrised successor to the single LIF neuron core. Holds N_NEURONS leaky integrate-and-fire neurons that update in parallel.
- Each neuron has its own membrane register, programmable threshold, refractory counter and ring-recurrent excitation.
- Sits behind the chip IO pad ring, in place of the single-neuron core. Scan insertion is handled at synthesis.

Parameters:
N_NEURONS, 4, number of neurons (>=2)
V_W, 6, membrane potential / threshold width, unsigned
W_W, 3, per-neuron input weight width, unsigned
LEAK, 1, constant subtracted per timestep
REFR_CYC, 2, refractory length in timesteps (0 = none)
REC_W, 2, recurrent weight added from ring neighbour spike
THRES_RST, 32, per-neuron threshold after reset
SEL_W, 2, threshold select width (>= clog2(N_NEURONS))

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
i_svalid  in  1  timestep strobe; neurons update only on cycles with i_svalid=1
i_wspike  in  N_NEURONS*W_W  input weight per neuron; neuron k uses bits [k*W_W +: W_W]
i_recc  in  1  enable ring recurrence (neuron k excited by neuron (k-1) mod N)
i_Thres  in  V_W  threshold load value
i_Thres_valid  in  1  threshold write strobe
i_Thres_sel  in  SEL_W  target neuron for threshold write
i_Thres_bcast  in  1  with i_Thres_valid: write all thresholds, ignoring sel
o_V  out  N_NEURONS*V_W  membrane potentials, registered
o_spike  out  N_NEURONS  spike pulses, registered, one cycle wide

Behaviour:
- Reset (async assert, sync release):
  - o_V=0, o_spike=0, refractory counters=0
  - every threshold=THRES_RST, internal prev-spike vector=0
- Cycles with i_svalid=0:
  - V, refractory counters and prev-spike vector hold.
  - o_spike=0.
- Per neuron k on an i_svalid=1 cycle, refractory counter r>0:
  - V<=0, r<=r-1, o_spike[k]<=0, inputs ignored.
- Per neuron k on an i_svalid=1 cycle, r==0:
  - sum = V + w_k + (i_recc & prev_spike[(k-1) mod N] ? REC_W : 0) - LEAK, computed at V_W+2 bits signed.
  - Saturate: sum<0 -> 0; sum>2^V_W-1 -> 2^V_W-1.
  - Fire condition: thres_k!=0 and sat_sum>=thres_k.
  - On fire: o_spike[k]<=1, V<=0, r<=REFR_CYC.
  - Otherwise: V<=sat_sum, o_spike[k]<=0.
- prev_spike<=o_spike next-state on every i_svalid=1 cycle, so recurrence uses the previous timestep's spikes.
- Threshold 0 = neuron disabled: it never fires but still integrates.
- Latency: o_V and o_spike reflect a timestep one clock after the i_svalid edge.
- Threshold write and timestep in the same cycle:
  - The compare uses the old threshold; the new value takes effect from the next timestep.
  - Bcast has priority over sel.
  - A sel value >= N_NEURONS is ignored.
- Reset asserted mid-operation clears everything immediately, including any in-progress refractory period.

Optional Feature:
- Macro: LIF_SPIKE_COUNT_EN.
- When defined, adds ports:
  - i_cnt_clr (in, 1)
  - o_spike_cnt (out, N_NEURONS*8)
- o_spike_cnt holds per-neuron spike counters that increment on each fire and saturate at 255.
- i_cnt_clr zeroes all counters synchronously. If i_cnt_clr coincides with a fire, the result is 0 (clear wins).
- Counters reset to 0.
- When the macro is undefined, the ports and counters are absent and the rest of the behaviour is identical.

Test Plan:
- Integrate and fire: thres0=10, w0=4, i_recc=0, 4 consecutive timesteps -> V0 = 3, 6, 9, then o_spike[0]=1 with V0=0. Next 2 timesteps V0 stays 0 despite w0=4 (refractory). 3rd timestep V0=3.
- Saturation and floor: V1 driven to 62, thres1=63, w1=7 -> sat 63, fires. Separately w2=0 from V2=0 -> V2 stays 0, no underflow.
- Threshold write: write i_Thres=5 with sel=2 in the same cycle as a timestep where V2+w-1=6 with old thres 32 -> no spike. Next timestep with V2+w-1>=5 -> fires. Bcast of 0 -> no neuron fires at V=63.
- Recurrence: i_recc=1, thres0=3, w0=4 (neuron 0 fires at timestep 1), w1=0, thres1=1 -> at timestep 2, V1 = 0+0+2-1 = 1 and neuron 1 fires. With i_recc=0, V1 stays 0.
- Hold and reset: i_svalid=0 for 5 cycles -> o_V unchanged, o_spike=0. Assert rst_n low mid-refractory -> all outputs 0 and thresholds back to 32 with no clock edge needed.
- LIF_SPIKE_COUNT_EN: 300 fires on neuron 0 -> o_spike_cnt[0]=255. i_cnt_clr in the same cycle as a fire -> 0.
